// File: rtl/qkv_feed_scheduler_if.sv
// rtl/qkv_feed_scheduler_if.sv - Q/K/V memory read ports and Q/K/V downstream streams
// master: scheduler side; slave: memories plus dot-product side.
interface qkv_feed_scheduler_if #(
  parameter int QA_W   = 3,
  parameter int KA_W   = 3,
  parameter int DATA_W = 32
);
  logic              q_rd_en;
  logic [QA_W-1:0]   q_rd_addr;
  logic [DATA_W-1:0] q_rd_data;
  logic              k_rd_en;
  logic [KA_W-1:0]   k_rd_addr;
  logic [DATA_W-1:0] k_rd_data;
  logic              v_rd_en;
  logic [KA_W-1:0]   v_rd_addr;
  logic [DATA_W-1:0] v_rd_data;

  logic              Q_vld_out;
  logic              Q_rdy_in;
  logic [DATA_W-1:0] q_out;
  logic              K_vld_out;
  logic              K_rdy_in;
  logic [DATA_W-1:0] k_out;
  logic              V_vld_out;
  logic              V_rdy_in;
  logic [DATA_W-1:0] v_out;

  modport master (
    output q_rd_en, q_rd_addr, k_rd_en, k_rd_addr, v_rd_en, v_rd_addr,
    input  q_rd_data, k_rd_data, v_rd_data,
    output Q_vld_out, q_out, K_vld_out, k_out, V_vld_out, v_out,
    input  Q_rdy_in, K_rdy_in, V_rdy_in
  );

  modport slave (
    input  q_rd_en, q_rd_addr, k_rd_en, k_rd_addr, v_rd_en, v_rd_addr,
    output q_rd_data, k_rd_data, v_rd_data,
    input  Q_vld_out, q_out, K_vld_out, k_out, V_vld_out, v_out,
    output Q_rdy_in, K_rdy_in, V_rdy_in
  );
endinterface

// File: rtl/qkv_feed_scheduler.sv
// rtl/qkv_feed_scheduler.sv - Feeds one attention tile (Q row, then SEQ_LEN K/V pairs per row) to the dot product
// Optional QKV_SCHED_PERF_EN adds stall_cycles/bubble_cycles counters.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

module qkv_feed_scheduler #(
  parameter int SEQ_LEN = `MAX_SEQ_LENGTH,
  parameter int MAX_Q   = `MAX_SEQ_LENGTH,
  parameter int DATA_W  = 32,
  parameter int QA_W    = $clog2(MAX_Q),
  parameter int KA_W    = $clog2(SEQ_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [QA_W:0]       num_q_rows,
  output logic                busy,
  output logic                done,
`ifdef QKV_SCHED_PERF_EN
  output logic [31:0]         stall_cycles,
  output logic [31:0]         bubble_cycles,
`endif
  qkv_feed_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [KA_W:0] SEQ_CNT  = (KA_W+1)'(SEQ_LEN);
  localparam logic [KA_W:0] SEQ_LAST = (KA_W+1)'(SEQ_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic [QA_W:0]     num_q;
  logic [QA_W:0]     q_issue;
  logic [QA_W:0]     rows_done;
  logic [KA_W:0]     kv_issue;
  logic [KA_W:0]     v_accept;

  logic              q_inflight;
  logic              q_full;
  logic [DATA_W-1:0] q_buf;

  // K and V reads are always issued together, so one in-flight flag serves both FIFOs
  logic              kv_inflight;
  logic [DATA_W-1:0] k_mem [2];
  logic [DATA_W-1:0] v_mem [2];
  logic              k_wp, k_rp, v_wp, v_rp;
  logic [1:0]        k_cnt, v_cnt;

  logic              run;
  logic              start_tile;
  logic              q_fire, k_fire, v_fire;
  logic [2:0]        k_level, v_level;
  logic              q_issue_ok;
  logic              kv_issue_ok;
  logic              last_accept;

  assign run        = (state == RUN);
  assign start_tile = (state == IDLE) && start;
  assign q_fire     = q_full && bus.Q_rdy_in;
  assign k_fire     = (k_cnt != 2'd0) && bus.K_rdy_in;
  assign v_fire     = (v_cnt != 2'd0) && bus.V_rdy_in;

  // Credit the entry leaving this cycle so a full-rate stream keeps one pair in flight
  assign k_level = {1'b0, k_cnt} + {2'b0, kv_inflight} - {2'b0, k_fire};
  assign v_level = {1'b0, v_cnt} + {2'b0, kv_inflight} - {2'b0, v_fire};

  assign q_issue_ok = run && !q_full && !q_inflight && (q_issue < num_q) &&
                      ((q_issue == '0) || (kv_issue == SEQ_CNT));

  assign kv_issue_ok = run && (q_issue != '0) && (kv_issue < SEQ_CNT) &&
                       (k_level < 3'd2) && (v_level < 3'd2);

  assign last_accept = v_fire && (v_accept == SEQ_LAST) && (rows_done == num_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_q_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_accept) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE);
    bus.q_rd_en   = q_issue_ok;
    bus.q_rd_addr = q_issue[QA_W-1:0];
    bus.k_rd_en   = kv_issue_ok;
    bus.k_rd_addr = kv_issue[KA_W-1:0];
    bus.v_rd_en   = kv_issue_ok;
    bus.v_rd_addr = kv_issue[KA_W-1:0];
    bus.Q_vld_out = q_full;
    bus.q_out     = q_buf;
    bus.K_vld_out = (k_cnt != 2'd0);
    bus.k_out     = k_mem[k_rp];
    bus.V_vld_out = (v_cnt != 2'd0);
    bus.v_out     = v_mem[v_rp];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q       <= '0;
      q_issue     <= '0;
      rows_done   <= '0;
      kv_issue    <= '0;
      v_accept    <= '0;
      q_inflight  <= 1'b0;
      q_full      <= 1'b0;
      q_buf       <= '0;
      kv_inflight <= 1'b0;
      k_mem[0]    <= '0;
      k_mem[1]    <= '0;
      v_mem[0]    <= '0;
      v_mem[1]    <= '0;
      k_wp        <= 1'b0;
      k_rp        <= 1'b0;
      v_wp        <= 1'b0;
      v_rp        <= 1'b0;
      k_cnt       <= 2'd0;
      v_cnt       <= 2'd0;
    end else if (start_tile) begin
      // Leftovers from a tile whose last V beat its Q/K are dropped here
      num_q       <= num_q_rows;
      q_issue     <= '0;
      rows_done   <= '0;
      kv_issue    <= '0;
      v_accept    <= '0;
      q_inflight  <= 1'b0;
      q_full      <= 1'b0;
      kv_inflight <= 1'b0;
      k_wp        <= 1'b0;
      k_rp        <= 1'b0;
      v_wp        <= 1'b0;
      v_rp        <= 1'b0;
      k_cnt       <= 2'd0;
      v_cnt       <= 2'd0;
    end else begin
      q_inflight  <= q_issue_ok;
      kv_inflight <= kv_issue_ok;

      if (q_issue_ok) begin
        q_issue  <= q_issue + 1'b1;
        kv_issue <= '0;
      end else if (kv_issue_ok) begin
        kv_issue <= kv_issue + 1'b1;
      end

      if (q_inflight) begin
        q_buf  <= bus.q_rd_data;
        q_full <= 1'b1;
      end else if (q_fire) begin
        q_full <= 1'b0;
      end

      if (kv_inflight) begin
        k_mem[k_wp] <= bus.k_rd_data;
        v_mem[v_wp] <= bus.v_rd_data;
        k_wp        <= ~k_wp;
        v_wp        <= ~v_wp;
      end
      if (k_fire) begin
        k_rp <= ~k_rp;
      end
      if (v_fire) begin
        v_rp <= ~v_rp;
      end
      k_cnt <= k_cnt + {1'b0, kv_inflight} - {1'b0, k_fire};
      v_cnt <= v_cnt + {1'b0, kv_inflight} - {1'b0, v_fire};

      if (run && v_fire) begin
        if (v_accept == SEQ_LAST) begin
          v_accept  <= '0;
          rows_done <= rows_done + 1'b1;
        end else begin
          v_accept <= v_accept + 1'b1;
        end
      end
    end
  end

`ifdef QKV_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_tile) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else if (run) begin
      if ((q_full && !bus.Q_rdy_in) ||
          ((k_cnt != 2'd0) && !bus.K_rdy_in) ||
          ((v_cnt != 2'd0) && !bus.V_rdy_in)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((k_cnt == 2'd0) && ((kv_issue < SEQ_CNT) || kv_inflight)) begin
        bubble_cycles <= bubble_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_qkv_feed_scheduler.sv
// tb/tb_qkv_feed_scheduler.sv - Randomized self-checking bench for qkv_feed_scheduler
// Reference: expected Q/K/V transfer queues built from memory contents, plus busy/done timing model.
module tb_qkv_feed_scheduler;
  localparam int SEQ_LEN = 4;
  localparam int MAX_Q   = 4;
  localparam int QA_W    = 2;
  localparam int KA_W    = 2;
  localparam int DW      = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [QA_W:0]   num_q_rows;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qkv_feed_scheduler_if #(.QA_W(QA_W), .KA_W(KA_W), .DATA_W(DW)) bus ();

  qkv_feed_scheduler #(.SEQ_LEN(SEQ_LEN), .MAX_Q(MAX_Q), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_q_rows (num_q_rows),
    .busy       (busy),
    .done       (done),
    .bus        (bus.master)
  );

  logic [DW-1:0] q_mem [MAX_Q];
  logic [DW-1:0] k_mem [SEQ_LEN];
  logic [DW-1:0] v_mem [SEQ_LEN];

  always @(posedge clk) begin
    if (bus.q_rd_en) bus.q_rd_data <= q_mem[bus.q_rd_addr];
    if (bus.k_rd_en) bus.k_rd_data <= k_mem[bus.k_rd_addr];
    if (bus.v_rd_en) bus.v_rd_data <= v_mem[bus.v_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_k [$];
  logic [DW-1:0] exp_v [$];
  bit active   = 1'b0;
  bit done_due = 1'b0;
  bit post_rst = 1'b0;
  int cyc = 0;
  int start_cyc, done_cyc, first_qrd_cyc, first_qvld_cyc;
  int q_fires, k_fires, v_fires, rd_total, busy_cycles, done_pulses;
  int done_total = 0;
  int k_addr_log [$];

  always @(negedge clk) begin
    bit v_last;
    cyc++;
    v_last = 1'b0;
    if (rst) begin
      active   = 1'b0;
      done_due = 1'b0;
      post_rst = 1'b1;
      exp_q.delete();
      exp_k.delete();
      exp_v.delete();
    end else begin
      if (post_rst) begin
        chk("reset_ctrl", {busy, done, bus.q_rd_en, bus.k_rd_en, bus.v_rd_en,
                           bus.Q_vld_out, bus.K_vld_out, bus.V_vld_out}, 64'd0);
        chk("reset_data", {bus.q_out, bus.k_out, bus.v_out}, 64'd0);
        post_rst = 1'b0;
      end
      chk("busy", busy, active);
      chk("done", done, done_due);
      chk("kv_lockstep", {bus.k_rd_en, bus.k_rd_addr}, {bus.v_rd_en, bus.v_rd_addr});
      if (!active) chk("rd_while_idle", {bus.q_rd_en, bus.k_rd_en, bus.v_rd_en}, 64'd0);

      if (bus.Q_vld_out && bus.Q_rdy_in) begin
        q_fires++;
        if (exp_q.size() == 0) chk("q_extra_vld", bus.Q_vld_out, 64'd0);
        else chk("q_data", bus.q_out, exp_q.pop_front());
      end
      if (bus.K_vld_out && bus.K_rdy_in) begin
        k_fires++;
        if (exp_k.size() == 0) chk("k_extra_vld", bus.K_vld_out, 64'd0);
        else chk("k_data", bus.k_out, exp_k.pop_front());
      end
      if (bus.V_vld_out && bus.V_rdy_in) begin
        v_fires++;
        if (exp_v.size() == 0) chk("v_extra_vld", bus.V_vld_out, 64'd0);
        else begin
          chk("v_data", bus.v_out, exp_v.pop_front());
          v_last = (exp_v.size() == 0);
        end
      end

      if (bus.q_rd_en && first_qrd_cyc < 0) first_qrd_cyc = cyc;
      if (bus.Q_vld_out && first_qvld_cyc < 0) first_qvld_cyc = cyc;
      if (bus.k_rd_en) k_addr_log.push_back(int'(bus.k_rd_addr));
      rd_total    += int'(bus.q_rd_en) + int'(bus.k_rd_en) + int'(bus.v_rd_en);
      busy_cycles += int'(busy);
      if (done) begin
        done_pulses++;
        done_total++;
        done_cyc = cyc;
      end

      if (done_due) begin
        done_due = 1'b0;
        active   = 1'b0;
      end else if (!active && start) begin
        active = 1'b1;
        start_cyc = cyc;
        first_qrd_cyc = -1; first_qvld_cyc = -1; done_cyc = -1;
        q_fires = 0; k_fires = 0; v_fires = 0; rd_total = 0;
        busy_cycles = 0; done_pulses = 0;
        k_addr_log.delete();
        exp_q.delete(); exp_k.delete(); exp_v.delete();
        for (int r = 0; r < int'(num_q_rows); r++) begin
          exp_q.push_back(q_mem[r]);
          for (int i = 0; i < SEQ_LEN; i++) begin
            exp_k.push_back(k_mem[i]);
            exp_v.push_back(v_mem[i]);
          end
        end
        if (num_q_rows == '0) done_due = 1'b1;
      end else if (active && v_last) begin
        done_due = 1'b1;
      end
    end
  end

  int q_pct = 100, k_pct = 100, v_pct = 100;

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.Q_rdy_in = (int'($urandom_range(99)) < q_pct);
    bus.K_rdy_in = (int'($urandom_range(99)) < k_pct);
    bus.V_rdy_in = (int'($urandom_range(99)) < v_pct);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MAX_Q; i++) q_mem[i] = DW'($urandom);
    for (int i = 0; i < SEQ_LEN; i++) begin
      k_mem[i] = DW'($urandom);
      v_mem[i] = DW'($urandom);
    end
  endtask

  task automatic kick(input int n);
    tick();
    start = 1'b1;
    num_q_rows = (QA_W+1)'(n);
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done_total != d0) break;
    end
    chk({name, "_done_seen"}, done_total - d0, 64'd1);
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    rst = 1'b1;
    start = 1'b0;
    num_q_rows = '0;
    bus.Q_rdy_in = 1'b1;
    bus.K_rdy_in = 1'b1;
    bus.V_rdy_in = 1'b1;
    fill_mem();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // T1: two rows, all streams ready
    fill_mem();
    d0 = done_total;
    kick(2);
    wait_done("t1", d0);
    chk("t1_qrd_latency", first_qrd_cyc - start_cyc, 64'd1);
    chk("t1_qvld_latency", first_qvld_cyc - first_qrd_cyc, 64'd2);
    chk("t1_q_count", q_fires, 64'd2);
    chk("t1_k_count", k_fires, 64'd8);
    chk("t1_v_count", v_fires, 64'd8);
    chk("t1_done_pulses", done_pulses, 64'd1);
    chk("t1_kaddr_count", k_addr_log.size(), 64'd8);
    for (int i = 0; i < k_addr_log.size(); i++) chk("t1_kaddr", k_addr_log[i], i % SEQ_LEN);

    // T2: zero rows
    d0 = done_total;
    kick(0);
    wait_done("t2", d0);
    chk("t2_done_latency", done_cyc - start_cyc, 64'd1);
    chk("t2_busy_cycles", busy_cycles, 64'd1);
    chk("t2_no_reads", rd_total, 64'd0);

    // T3: K stalled for 5 cycles at the start of row 0
    fill_mem();
    d0 = done_total;
    kick(2);
    k_pct = 0;
    repeat (5) tick();
    @(negedge clk);
    chk("t3_k_rd_stopped", bus.k_rd_en, 64'd0);
    chk("t3_k_vld_held", bus.K_vld_out, 64'd1);
    k_pct = 100;
    wait_done("t3", d0);
    chk("t3_k_count", k_fires, 64'd8);
    chk("t3_v_count", v_fires, 64'd8);

    // T4: V ready at random, Q mostly ready
    fill_mem();
    q_pct = 70; v_pct = 50;
    d0 = done_total;
    kick(3);
    wait_done("t4", d0);
    chk("t4_k_count", k_fires, 64'd12);
    chk("t4_v_count", v_fires, 64'd12);
    q_pct = 100; v_pct = 100;

    // T5: reset in the middle of row 1 of 3, then a full fresh tile
    fill_mem();
    v_pct = 80;
    d0 = done_total;
    kick(3);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (q_fires >= 2) break;
    end
    chk("t5_reached_row1", q_fires, 64'd2);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("t5_no_done", done_total - d0, 64'd0);
    v_pct = 100;
    fill_mem();
    d0 = done_total;
    kick(3);
    wait_done("t5", d0);
    chk("t5_q_count", q_fires, 64'd3);
    chk("t5_v_count", v_fires, 64'd12);

    // T6: start re-pulsed while busy
    fill_mem();
    d0 = done_total;
    kick(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 1'b1;
      num_q_rows = (QA_W+1)'(i % 4 + 1);
    end
    wait_done("t6", d0);
    repeat (5) tick();
    chk("t6_single_done", done_total - d0, 64'd1);
    chk("t6_q_count", q_fires, 64'd2);
    chk("t6_k_count", k_fires, 64'd8);

    // Random tiles
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(0, MAX_Q));
      q_pct = int'($urandom_range(40, 100));
      v_pct = int'($urandom_range(30, 100));
      k_pct = 100;
      fill_mem();
      d0 = done_total;
      kick(n);
      wait_done("rand", d0);
      chk("rand_q_count", q_fires, n);
      chk("rand_v_count", v_fires, n * SEQ_LEN);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
